dbus_ram_responder: RTL and testbench
=====================================

DBUS_RAM_RESPONDER -- requirements
Module: dbus_ram_responder

Interface
REQ-001 Parameter LATENCY, default 2, is the number of cycles from request acceptance to data_ok; the legal range is 1..15.
REQ-002 Parameter DEPTH_LOG2, default 12, sets the memory size in 64-bit words as 2**DEPTH_LOG2.
REQ-003 Parameter BASE_ADDR, default 64'h8000_0000, is the byte address of word 0.
REQ-004 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  is the reset, asynchronous and active-high.
REQ-006 dreq  input  dbus_req_t  carries the request: valid, addr, size, strobe, data.
REQ-007 dresp  output  dbus_resp_t  carries the response: addr_ok, data_ok, data.
REQ-008 bd_we  input  1  is the backdoor preload write enable (bench or page-table loader).
REQ-009 bd_idx  input  DEPTH_LOG2  is the backdoor word index.
REQ-010 bd_data  input  64  is the backdoor full-word write data.
REQ-011 oob  output  1  pulses together with data_ok when the completed request was out of range.
REQ-012 txn_cnt  output  32  counts completed transactions and wraps at 2**32.

Function
REQ-013 The FSM SHALL have the states IDLE, BUSY and RESP.
REQ-014 In IDLE, dresp.addr_ok SHALL equal dreq.valid combinationally; it SHALL be 0 in every other state.
REQ-015 Acceptance SHALL occur in an IDLE cycle with dreq.valid=1, latching addr, strobe and data, and loading the wait counter with LATENCY-1.
REQ-016 After acceptance the state SHALL be BUSY, or RESP directly when LATENCY=1.
REQ-017 In BUSY the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter is 0.
REQ-018 dresp.data_ok SHALL be a registered output, high for exactly one cycle, in the RESP state, LATENCY cycles after the acceptance cycle.
REQ-019 RESP SHALL always return to IDLE on the next edge; with valid held high, the next acceptance follows in the cycle after data_ok, giving a throughput of one transaction per LATENCY+1 cycles.
REQ-020 dreq fields changing after acceptance SHALL have no effect; only latched values are used.
REQ-021 The word index SHALL be (addr-BASE_ADDR)>>3; addr[2:0] is ignored for word select.
REQ-022 size is not used for data formatting; the full aligned word is always returned.
REQ-023 A request is in range when BASE_ADDR <= addr < BASE_ADDR + 8*2**DEPTH_LOG2.
REQ-024 Read, in range (strobe==0): dresp.data in the RESP cycle SHALL be the word at the index, sampled on the edge entering RESP.
REQ-025 Write, in range (strobe!=0): byte lane i SHALL be updated from data[8i+7:8i] where strobe[i]=1, committed on the edge entering RESP; dresp.data SHALL be 0.
REQ-026 Out of range: dresp.data SHALL be 0, any write SHALL be dropped, and oob SHALL be 1 in the RESP cycle; the transaction still completes normally.
REQ-027 dresp.data SHALL hold 0 outside the RESP cycle.
REQ-028 A backdoor write SHALL update memory on any cycle with bd_we=1.
REQ-029 If a backdoor write and a bus write hit the same word on the same edge, the bus-written lanes SHALL win and the other lanes SHALL take bd_data.
REQ-030 txn_cnt SHALL increment on each edge leaving RESP.

Reset
REQ-031 rst=1 SHALL force state IDLE, counter 0, data_ok 0, oob 0, dresp.data 0 and txn_cnt 0, immediately and independent of clk.
REQ-032 Reset during BUSY SHALL abort the transaction: no data_ok, and no write commit if the commit edge has not yet occurred.
REQ-033 Memory contents SHALL be preserved across reset.
REQ-034 addr_ok SHALL be 0 while rst=1.

Structure
REQ-035 dbus_req_t, dbus_resp_t, strobe_t, msize_t and u64 SHALL come from the shared package common; the FSM state enum SHALL be local.
REQ-036 The storage array with byte-lane write and backdoor port SHALL be one sub-module, dbus_ram_array; the FSM, counter and decode SHALL live in the top.

Verification
REQ-037 Preload word 0 with 64'h1122_3344_5566_7788, then read addr 64'h8000_0000 at LATENCY=2: addr_ok in cycle T, data_ok in cycle T+2 with data=64'h1122_3344_5566_7788, and txn_cnt=1.
REQ-038 Write addr 64'h8000_0008, strobe 8'h0F, data 64'hAAAA_BBBB_CCCC_DDDD over preloaded 0, then read it back: the read returns 64'h0000_0000_CCCC_DDDD.
REQ-039 Read addr 64'h7FFF_FFF8 and then 64'h8000_8000 (DEPTH_LOG2=12): both give data=0 and oob=1; a write to 64'h8000_8000 leaves memory unchanged.
REQ-040 With valid held at 1 and the address changed in the data_ok cycle (MMU walk style), three back-to-back reads complete at cycles T+2, T+5 and T+8 with the correct words.
REQ-041 Assert rst in the cycle after a write is accepted at LATENCY=3: no data_ok, the target word is unchanged, and the state is IDLE on the next edge.
REQ-042 With LATENCY=1, data_ok occurs in the cycle after acceptance; a backdoor write and a bus write with strobe 8'h01 to the same word on the same edge give byte 0 from the bus and the other bytes from bd_data.

Source files
------------

// File: rtl/dbus_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : common
//  Purpose   : Shared data-bus types used by the RAM responder and its
//              storage array. Request/response structs, byte-strobe and size
//              types, plus a byte-lane merge helper.
//  Revision  : 1.0  initial release
// ============================================================================
package common;

    typedef logic [63:0] u64;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic    valid;
        u64      addr;
        msize_t  size;
        strobe_t strobe;
        u64      data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    // log2 of the word size in bytes
    localparam int c_WORD_SHIFT = 3;

    // Replace the byte lanes of old_word selected by strobe with new_word.
    function automatic u64 merge_lanes(input u64 old_word, input u64 new_word,
                                       input strobe_t strobe);
        u64 result;
        result = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strobe[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_ram_array.sv
`default_nettype none
// ============================================================================
//  Module    : dbus_ram_array
//  Purpose   : Word-organised storage with a byte-lane bus write port, a
//              full-word backdoor write port and a combinational read port.
//              Contents are not reset.
//  Ports     : clk        clock
//              i_bus_we   bus write enable (byte lanes from i_strobe)
//              i_idx      word index for bus write and read
//              i_strobe   byte-lane enables for the bus write
//              i_wdata    bus write data
//              i_bd_we    backdoor write enable
//              i_bd_idx   backdoor word index
//              i_bd_data  backdoor full-word data
//              o_rdata    word at i_idx (combinational)
//  Revision  : 1.0  initial release
// ============================================================================
module dbus_ram_array
    import common::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  i_bus_we,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  strobe_t               i_strobe,
    input  u64                    i_wdata,
    input  logic                  i_bd_we,
    input  logic [DEPTH_LOG2-1:0] i_bd_idx,
    input  u64                    i_bd_data,
    output u64                    o_rdata
);

    u64 r_mem [0:(1<<DEPTH_LOG2)-1];

    u64 w_bus_base;
    u64 w_bus_word;

    // When both ports hit the same word, the unstrobed lanes come from the
    // backdoor data so the later bus assignment carries both contributions.
    assign w_bus_base = (i_bd_we && (i_bd_idx == i_idx)) ? i_bd_data : r_mem[i_idx];
    assign w_bus_word = merge_lanes(w_bus_base, i_wdata, i_strobe);

    always_ff @(posedge clk) begin
        if (i_bd_we)  r_mem[i_bd_idx] <= i_bd_data;
        if (i_bus_we) r_mem[i_idx]    <= w_bus_word;
    end

    assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/dbus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module    : dbus_ram_responder
//  Purpose   : Fixed-latency RAM model answering a 64-bit data bus. Accepts
//              one request at a time, completes it LATENCY cycles later with a
//              one-cycle data_ok, flags out-of-range addresses and counts
//              completed transactions.
//  Ports     : clk      clock
//              rst      asynchronous active-high reset
//              dreq     bus request (valid, addr, size, strobe, data)
//              dresp    bus response (addr_ok, data_ok, data)
//              bd_we    backdoor preload write enable
//              bd_idx   backdoor word index
//              bd_data  backdoor word data
//              oob      out-of-range flag, valid with data_ok
//              txn_cnt  completed transaction count (wraps)
//  Revision  : 1.0  initial release
// ============================================================================
module dbus_ram_responder
    import common::*;
#(
    parameter int          LATENCY    = 2,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  dbus_req_t             dreq,
    output dbus_resp_t            dresp,
    input  logic                  bd_we,
    input  logic [DEPTH_LOG2-1:0] bd_idx,
    input  u64                    bd_data,
    output logic                  oob,
    output logic [31:0]           txn_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    u64                    r_addr;
    u64                    r_data;
    strobe_t               r_strobe;
    logic                  r_data_ok;
    logic                  r_oob;
    u64                    r_rdata;
    logic [31:0]           r_txn_cnt;

    logic                  w_accept;
    logic                  w_enter_resp;
    u64                    w_cur_addr;
    u64                    w_cur_data;
    strobe_t               w_cur_strobe;
    u64                    w_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_bus_we;
    u64                    w_mem_rdata;
    msize_t                w_unused_size;

    // size never affects formatting; the whole aligned word is returned
    assign w_unused_size = dreq.size;

    assign w_accept     = (r_state == S_IDLE) && dreq.valid && !rst;
    // The edge entering RESP is the commit/sample edge. With LATENCY=1 that
    // is the acceptance edge itself, so the live request must be used there.
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP) && !rst;

    assign w_cur_addr   = (r_state == S_IDLE) ? dreq.addr   : r_addr;
    assign w_cur_data   = (r_state == S_IDLE) ? dreq.data   : r_data;
    assign w_cur_strobe = (r_state == S_IDLE) ? dreq.strobe : r_strobe;

    // Range test via the offset avoids overflow of BASE_ADDR + size.
    assign w_off      = w_cur_addr - BASE_ADDR;
    assign w_in_range = (w_cur_addr >= BASE_ADDR) &&
                        ((w_off >> (DEPTH_LOG2 + c_WORD_SHIFT)) == 64'd0);
    assign w_idx      = w_off[DEPTH_LOG2+c_WORD_SHIFT-1:c_WORD_SHIFT];
    assign w_bus_we   = w_enter_resp && w_in_range && (w_cur_strobe != 8'd0);

    dbus_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk       (clk),
        .i_bus_we  (w_bus_we),
        .i_idx     (w_idx),
        .i_strobe  (w_cur_strobe),
        .i_wdata   (w_cur_data),
        .i_bd_we   (bd_we),
        .i_bd_idx  (bd_idx),
        .i_bd_data (bd_data),
        .o_rdata   (w_mem_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state. The BUSY exit fires when the counter steps to 0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (dreq.valid) w_next = (LATENCY == 1) ? S_RESP : S_BUSY;
            S_BUSY:  if (r_cnt <= 4'd1) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: request latch, wait counter, registered response, counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strobe  <= '0;
            r_data_ok <= 1'b0;
            r_oob     <= 1'b0;
            r_rdata   <= '0;
            r_txn_cnt <= 32'd0;
        end else begin
            r_data_ok <= w_enter_resp;
            r_oob     <= w_enter_resp && !w_in_range;
            r_rdata   <= (w_enter_resp && w_in_range && (w_cur_strobe == 8'd0))
                         ? w_mem_rdata : 64'd0;
            if (w_accept) begin
                r_addr   <= dreq.addr;
                r_data   <= dreq.data;
                r_strobe <= dreq.strobe;
                r_cnt    <= 4'(LATENCY - 1);
            end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_RESP) r_txn_cnt <= r_txn_cnt + 32'd1;
        end
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = (r_state == S_IDLE) && dreq.valid && !rst;
        dresp.data_ok = r_data_ok;
        dresp.data    = r_rdata;
    end

    assign oob     = r_oob;
    assign txn_cnt = r_txn_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dbus_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module    : tb_dbus_ram_responder
//  Purpose   : Self-checking bench. Three responders with LATENCY 1, 2, 3
//              share clock and reset; a word-array model predicts every
//              response.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_dbus_ram_responder;
    import common::*;

    localparam int          N     = 3;      // instance k has LATENCY k+1
    localparam int          DL2   = 12;
    localparam int          WORDS = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    dbus_req_t       dreq    [N];
    dbus_resp_t      dresp   [N];
    logic            bd_we   [N];
    logic [DL2-1:0]  bd_idx  [N];
    u64              bd_data [N];
    logic            oob     [N];
    logic [31:0]     txn_cnt [N];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            dbus_ram_responder #(
                .LATENCY    (g + 1),
                .DEPTH_LOG2 (DL2),
                .BASE_ADDR  (BASE)
            ) u_dut (
                .clk     (clk),
                .rst     (rst),
                .dreq    (dreq[g]),
                .dresp   (dresp[g]),
                .bd_we   (bd_we[g]),
                .bd_idx  (bd_idx[g]),
                .bd_data (bd_data[g]),
                .oob     (oob[g]),
                .txn_cnt (txn_cnt[g])
            );
        end
    endgenerate

    u64          mdl  [N][WORDS];
    int unsigned ntxn [N];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input u64 obs, input u64 exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input u64 a);
        return (a >= BASE) && (a < BASE + 64'(8 * WORDS));
    endfunction

    // One bus transaction on instance k, checked cycle by cycle.
    task automatic do_txn(input int k, input u64 addr, input strobe_t strb,
                          input u64 wdata, input bit hold, input u64 next_addr,
                          output int t_acc, output int t_ok, output u64 got);
        u64 exp_data;
        bit exp_oob;
        int idx;
        int lat;
        lat = k + 1;
        @(posedge clk); #1;
        check("idle_data_ok", 64'(dresp[k].data_ok), 64'd0);
        check("idle_data",    dresp[k].data,         64'd0);
        check("txn_cnt",      64'(txn_cnt[k]),       64'(ntxn[k]));
        dreq[k].valid  = 1'b1;
        dreq[k].addr   = addr;
        dreq[k].strobe = strb;
        dreq[k].data   = wdata;
        dreq[k].size   = MSIZE8;
        #1;
        check("addr_ok_idle", 64'(dresp[k].addr_ok), 64'd1);
        t_acc = cyc;
        if (!in_rng(addr)) begin
            exp_data = 64'd0;
            exp_oob  = 1'b1;
        end else begin
            idx     = int'((addr - BASE) >> 3);
            exp_oob = 1'b0;
            if (strb == 8'd0) begin
                exp_data = mdl[k][idx];
            end else begin
                exp_data = 64'd0;
                for (int b = 0; b < 8; b++)
                    if (strb[b]) mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        t_ok = -1;
        got  = 64'd0;
        for (int n = 1; n <= lat; n++) begin
            @(posedge clk); #1;
            dreq[k].valid = hold;
            if (hold && n == lat) begin
                dreq[k].addr   = next_addr;
                dreq[k].strobe = 8'd0;
            end else begin
                dreq[k].addr   = {$urandom, $urandom};
                dreq[k].strobe = 8'($urandom);
                dreq[k].data   = {$urandom, $urandom};
            end
            #1;
            check("addr_ok_busy", 64'(dresp[k].addr_ok), 64'd0);
            check("data_ok",      64'(dresp[k].data_ok), 64'(n == lat));
            if (n == lat) begin
                check("resp_data", dresp[k].data, exp_data);
                check("resp_oob",  64'(oob[k]),   64'(exp_oob));
                t_ok = cyc;
                got  = dresp[k].data;
            end else begin
                check("busy_data", dresp[k].data, 64'd0);
                check("busy_oob",  64'(oob[k]),   64'd0);
            end
        end
        ntxn[k]++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int ta, to, ta1, to1, to2, to3;
        u64 got, wd, bdd, a;
        int r;

        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            dreq[k] = '0; bd_we[k] = 1'b0; bd_idx[k] = '0; bd_data[k] = '0;
            ntxn[k] = 0;
        end

        // reset state, addr_ok masked during reset
        #1;
        for (int k = 0; k < N; k++) begin
            dreq[k].valid = 1'b1;
            #1;
            check("rst_addr_ok", 64'(dresp[k].addr_ok), 64'd0);
            check("rst_data_ok", 64'(dresp[k].data_ok), 64'd0);
            check("rst_data",    dresp[k].data,         64'd0);
            check("rst_oob",     64'(oob[k]),           64'd0);
            check("rst_txn",     64'(txn_cnt[k]),       64'd0);
            dreq[k].valid = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // backdoor preload of words 0..31 on every instance
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                bd_we[k] = 1'b1; bd_idx[k] = DL2'(i); bd_data[k] = {$urandom, $urandom};
                mdl[k][i] = bd_data[k];
            end
        end
        @(posedge clk); #1;
        bd_idx[1] = DL2'(0); bd_data[1] = 64'h1122_3344_5566_7788; mdl[1][0] = bd_data[1];
        bd_we[0] = 1'b0; bd_we[2] = 1'b0;
        @(posedge clk); #1;
        bd_idx[1] = DL2'(1); bd_data[1] = 64'd0; mdl[1][1] = 64'd0;
        @(posedge clk); #1;
        bd_we[1] = 1'b0;

        // first read, LATENCY=2
        do_txn(1, BASE, 8'h00, 64'd0, 1'b0, 64'd0, ta, to, got);
        check("rd_word0", got, 64'h1122_3344_5566_7788);
        check("rd_word0_lat", 64'(to - ta), 64'd2);

        // partial write then read back
        do_txn(1, BASE + 64'd8, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 64'd0, ta, to, got);
        do_txn(1, BASE + 64'd8, 8'h00, 64'd0, 1'b0, 64'd0, ta, to, got);
        check("rd_partial", got, 64'h0000_0000_CCCC_DDDD);

        // out-of-range below, above, and a dropped write aliasing word 0
        do_txn(1, 64'h7FFF_FFF8, 8'h00, 64'd0, 1'b0, 64'd0, ta, to, got);
        do_txn(1, 64'h8000_8000, 8'h00, 64'd0, 1'b0, 64'd0, ta, to, got);
        do_txn(1, 64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 64'd0, ta, to, got);
        do_txn(1, BASE, 8'h00, 64'd0, 1'b0, 64'd0, ta, to, got);
        check("oob_wr_dropped", got, 64'h1122_3344_5566_7788);

        // back-to-back reads with valid held, address switched at data_ok
        do_txn(1, BASE + 64'd16, 8'h00, 64'd0, 1'b1, BASE + 64'd24, ta1, to1, got);
        do_txn(1, BASE + 64'd24, 8'h00, 64'd0, 1'b1, BASE + 64'd32, ta,  to2, got);
        do_txn(1, BASE + 64'd32, 8'h00, 64'd0, 1'b0, 64'd0,        ta,  to3, got);
        check("b2b_t1", 64'(to1 - ta1), 64'd2);
        check("b2b_t2", 64'(to2 - ta1), 64'd5);
        check("b2b_t3", 64'(to3 - ta1), 64'd8);

        // reset in the cycle after a write is accepted, LATENCY=3
        @(posedge clk); #1;
        dreq[2].valid = 1'b1; dreq[2].addr = BASE + 64'd24;
        dreq[2].strobe = 8'hFF; dreq[2].data = {$urandom, $urandom};
        #1;
        check("abort_accept", 64'(dresp[2].addr_ok), 64'd1);
        @(posedge clk); #1;
        dreq[2].valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_data_ok", 64'(dresp[2].data_ok), 64'd0);
        dreq[2].valid = 1'b1;
        #1;
        check("abort_addr_ok", 64'(dresp[2].addr_ok), 64'd0);
        dreq[2].valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("abort_txn", 64'(txn_cnt[k]), 64'd0);
            ntxn[k] = 0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_data_ok2", 64'(dresp[2].data_ok), 64'd0);
        do_txn(2, BASE + 64'd24, 8'h00, 64'd0, 1'b0, 64'd0, ta, to, got);
        check("abort_lat", 64'(to - ta), 64'd3);

        // LATENCY=1 with backdoor and bus hitting word 5 on the same edge
        @(posedge clk); #1;
        wd  = {$urandom, $urandom};
        bdd = {$urandom, $urandom};
        dreq[0].valid = 1'b1; dreq[0].addr = BASE + 64'd40;
        dreq[0].strobe = 8'h01; dreq[0].data = wd;
        bd_we[0] = 1'b1; bd_idx[0] = DL2'(5); bd_data[0] = bdd;
        #1;
        check("coll_addr_ok", 64'(dresp[0].addr_ok), 64'd1);
        @(posedge clk); #1;
        dreq[0].valid = 1'b0; bd_we[0] = 1'b0;
        #1;
        check("coll_data_ok", 64'(dresp[0].data_ok), 64'd1);
        check("coll_data",    dresp[0].data,         64'd0);
        check("coll_oob",     64'(oob[0]),           64'd0);
        ntxn[0]++;
        mdl[0][5] = {bdd[63:8], wd[7:0]};
        do_txn(0, BASE + 64'd40, 8'h00, 64'd0, 1'b0, 64'd0, ta, to, got);
        check("coll_readback", got, {bdd[63:8], wd[7:0]});
        check("lat1", 64'(to - ta), 64'd1);

        // randomized traffic on all instances
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 12; t++) begin
                r = int'($urandom_range(0, 7));
                if (r == 0)      a = BASE + 64'(8 * WORDS) + 64'($urandom_range(0, 8191));
                else if (r == 1) a = BASE - 64'($urandom_range(1, 800));
                else             a = BASE + 64'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
                do_txn(k, a, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                       {$urandom, $urandom}, 1'b0, 64'd0, ta, to, got);
            end
        end

        @(posedge clk); #1;
        for (int k = 0; k < N; k++) check("final_txn", 64'(txn_cnt[k]), 64'(ntxn[k]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
